// File: rtl/satd_diff_stream.sv
// -----------------------------------------------------------------------------
// satd_diff_stream
//
// Difference front-end for the SATD datapath. Each accepted beat is one row of
// NUM_INPUTS original/current pixel pairs. The block emits NUM_INPUTS signed
// (WIDTH+1)-bit differences per row under valid/ready flow control. Each row is
// tagged with its index inside a BLOCK_ROWS-row block. An output register plus
// a skid register give full throughput with a registered in_ready.
//
// Optional feature macro: SATD_DIFF_SAD_EN
//   When defined, adds out_sad: the cumulative block SAD through each row.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   clr        synchronous flush and block restart, active-high
//   in_valid   row present on ORG/CUR
//   in_ready   block can accept a row (registered, == skid register empty)
//   ORG, CUR   original / current pixels, lane i at [(i+1)*WIDTH-1 : i*WIDTH]
//   out_valid  row of differences present
//   out_ready  downstream accepts the row
//   out_diff   signed differences, lane i at [(i+1)*(WIDTH+1)-1 : i*(WIDTH+1)]
//   out_row    row index of the output row within its block
//   out_last   high on the last row of a block
//   out_sad    (SATD_DIFF_SAD_EN only) cumulative block SAD through this row
// -----------------------------------------------------------------------------
module satd_diff_stream #(
   parameter int WIDTH      = 8,
   parameter int NUM_INPUTS = 8,
   parameter int BLOCK_ROWS = 8,
   localparam int RW        = $clog2(BLOCK_ROWS),
   localparam int DW        = (WIDTH + 1) * NUM_INPUTS
`ifdef SATD_DIFF_SAD_EN
  ,localparam int SW        = WIDTH + $clog2(NUM_INPUTS * BLOCK_ROWS)
`endif
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH*NUM_INPUTS-1:0] ORG,
   input  logic [WIDTH*NUM_INPUTS-1:0] CUR,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DW-1:0]               out_diff,
   output logic [RW-1:0]               out_row,
   output logic                        out_last
`ifdef SATD_DIFF_SAD_EN
  ,output logic [SW-1:0]               out_sad
`endif
);

   localparam logic [RW-1:0] ROW_LAST = RW'(BLOCK_ROWS - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   // One storage entry: everything that travels with a row.
   typedef struct packed {
      logic [DW-1:0] diff;
      logic [RW-1:0] row;
      logic          last;
`ifdef SATD_DIFF_SAD_EN
      logic [SW-1:0] sad;
`endif
   } entry_t;

   entry_t          out_r;
   entry_t          skid_r;
   entry_t          new_s;
   logic [DW-1:0]   diff_s;
   logic            out_valid_r;
   logic            skid_valid_r;
   logic            in_ready_r;
   logic [RW-1:0]   row_cnt_r;
   logic            in_xfer_s;
   logic            drain_s;

`ifdef SATD_DIFF_SAD_EN
   logic [SW-1:0]   acc_r;
   logic [SW-1:0]   row_sum_s;

   // Magnitude of a (WIDTH+1)-bit two's complement difference; always fits in WIDTH bits.
   function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH:0] d);
      logic [WIDTH:0] neg;
      neg = (~d) + {{WIDTH{1'b0}}, 1'b1};
      return d[WIDTH] ? neg[WIDTH-1:0] : d[WIDTH-1:0];
   endfunction
`endif

   assign in_xfer_s = in_valid & in_ready_r;
   // Output register frees up this edge when empty or being consumed.
   assign drain_s   = ~out_valid_r | out_ready;

   // Per-lane zero-extended subtraction; the extra bit makes overflow impossible.
   always_comb begin
      diff_s = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         diff_s[i*(WIDTH+1) +: (WIDTH+1)] = {1'b0, ORG[i*WIDTH +: WIDTH]}
                                          - {1'b0, CUR[i*WIDTH +: WIDTH]};
      end
   end

`ifdef SATD_DIFF_SAD_EN
   // Sum of absolute differences across the lanes of the incoming row.
   always_comb begin
      row_sum_s = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         row_sum_s = row_sum_s
                   + {{(SW-WIDTH){1'b0}}, abs_mag(diff_s[i*(WIDTH+1) +: (WIDTH+1)])};
      end
   end
`endif

   // Assemble the entry for the incoming row; row index is the pre-increment count.
   always_comb begin
      new_s      = '0;
      new_s.diff = diff_s;
      new_s.row  = row_cnt_r;
      new_s.last = (row_cnt_r == ROW_LAST);
`ifdef SATD_DIFF_SAD_EN
      // Row 0 restarts the block sum rather than adding to the previous block.
      new_s.sad  = (row_cnt_r == '0) ? row_sum_s : (acc_r + row_sum_s);
`endif
   end

   // Output register / skid register pipeline with registered in_ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_r        <= '0;
         skid_r       <= '0;
         out_valid_r  <= 1'b0;
         skid_valid_r <= 1'b0;
         in_ready_r   <= 1'b0;
      end else if (clr) begin
         out_valid_r  <= 1'b0;
         skid_valid_r <= 1'b0;
         in_ready_r   <= 1'b1;
      end else if (drain_s) begin
         if (skid_valid_r) begin
            // in_ready was low, so no input can arrive while the skid empties.
            out_r        <= skid_r;
            out_valid_r  <= 1'b1;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
         end else begin
            if (in_xfer_s) begin
               out_r <= new_s;
            end else begin
               out_r <= out_r;
            end
            out_valid_r  <= in_xfer_s;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
         end
      end else begin
         if (in_xfer_s) begin
            skid_r       <= new_s;
            skid_valid_r <= 1'b1;
            in_ready_r   <= 1'b0;
         end else begin
            in_ready_r   <= ~skid_valid_r;
         end
      end
   end

   // Row counter advances on every accepted row and wraps at the block size.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_cnt_r <= '0;
      end else if (clr) begin
         row_cnt_r <= '0;
      end else if (in_xfer_s) begin
         if (row_cnt_r == ROW_LAST) begin
            row_cnt_r <= '0;
         end else begin
            row_cnt_r <= row_cnt_r + ROW_ONE;
         end
      end else begin
         row_cnt_r <= row_cnt_r;
      end
   end

`ifdef SATD_DIFF_SAD_EN
   // Block SAD accumulator follows the cumulative sum stored with each row.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r <= '0;
      end else if (clr) begin
         acc_r <= '0;
      end else if (in_xfer_s) begin
         acc_r <= new_s.sad;
      end else begin
         acc_r <= acc_r;
      end
   end

   assign out_sad   = out_r.sad;
`endif

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_diff  = out_r.diff;
   assign out_row   = out_r.row;
   assign out_last  = out_r.last;

endmodule

// File: tb/tb_satd_diff_stream.sv
// -----------------------------------------------------------------------------
// tb_satd_diff_stream
//
// Scoreboard bench for satd_diff_stream at default parameters. The monitor
// predicts every input transfer from the handshake seen at the falling edge,
// pushes the expected row (computed with plain integer arithmetic) into a
// queue, and pops and compares whenever an output transfer occurs. It also
// checks that out_valid / in_ready match the number of rows in flight and that
// held outputs stay stable.
// -----------------------------------------------------------------------------
module tb_satd_diff_stream;

   localparam int W  = 8;
   localparam int N  = 8;
   localparam int BR = 8;
   localparam int RW = 3;
   localparam int DW = (W + 1) * N;
   localparam int IW = W * N;
`ifdef SATD_DIFF_SAD_EN
   localparam int SW = W + 6;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           clr = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [IW-1:0]  ORG = '0;
   logic [IW-1:0]  CUR = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [DW-1:0]  out_diff;
   logic [RW-1:0]  out_row;
   logic           out_last;
`ifdef SATD_DIFF_SAD_EN
   logic [SW-1:0]  out_sad;
`endif

   satd_diff_stream dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ORG       (ORG),
      .CUR       (CUR),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_diff  (out_diff),
      .out_row   (out_row),
      .out_last  (out_last)
`ifdef SATD_DIFF_SAD_EN
     ,.out_sad   (out_sad)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] diff;
      int            row;
      bit            last;
      int            sad;
   } exp_t;

   exp_t          q[$];
   exp_t          e;
   int            checks = 0;
   int            errors = 0;
   int            mrow = 0;
   int            macc = 0;
   int            d;
   int            s;
   logic [DW-1:0] dv;
   bit            prev_rst = 1'b0;
   bit            prev_hold = 1'b0;
   logic [DW-1:0] h_diff;
   logic [RW-1:0] h_row;
   logic          h_last;
   int            ready_mode = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard: everything is sampled at the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("rst_out_valid", out_valid, 1'b0);
         check("rst_out_row", out_row, 3'd0);
         check("rst_out_last", out_last, 1'b0);
         q.delete();
         mrow      = 0;
         macc      = 0;
         prev_rst  = 1'b0;
         prev_hold = 1'b0;
      end else begin
         if (prev_rst) begin
            check("out_valid_vs_occupancy", out_valid, (q.size() > 0));
            check("in_ready_vs_occupancy", in_ready, (q.size() < 2));
         end
         if (prev_hold) begin
            check("hold_diff", out_diff, h_diff);
            check("hold_row", out_row, h_row);
            check("hold_last", out_last, h_last);
         end
         prev_rst  = 1'b1;
         prev_hold = out_valid && !out_ready && !clr;
         h_diff    = out_diff;
         h_row     = out_row;
         h_last    = out_last;
         if (clr) begin
            q.delete();
            mrow = 0;
            macc = 0;
         end else begin
            if (out_valid && out_ready) begin
               check("output_expected", (q.size() != 0), 1'b1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  check("out_diff", out_diff, e.diff);
                  check("out_row", out_row, e.row);
                  check("out_last", out_last, e.last);
`ifdef SATD_DIFF_SAD_EN
                  check("out_sad", out_sad, e.sad);
`endif
               end
            end
            if (in_valid && in_ready) begin
               dv = '0;
               s  = 0;
               for (int i = 0; i < N; i++) begin
                  d = int'(ORG[i*W +: W]) - int'(CUR[i*W +: W]);
                  dv[i*(W+1) +: (W+1)] = d[W:0];
                  s += (d < 0) ? -d : d;
               end
               macc   = (mrow == 0) ? s : (macc + s);
               e.diff = dv;
               e.row  = mrow;
               e.last = (mrow == BR - 1);
               e.sad  = macc;
               q.push_back(e);
               mrow = (mrow + 1) % BR;
            end
         end
      end
   end

   // Random backpressure when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 2) begin
            out_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   function automatic logic [IW-1:0] rand_row();
      logic [IW-1:0] r;
      for (int i = 0; i < N; i++) begin
         case ($urandom_range(0, 3))
            0:       r[i*W +: W] = 8'd0;
            1:       r[i*W +: W] = 8'd255;
            default: r[i*W +: W] = 8'($urandom_range(0, 255));
         endcase
      end
      return r;
   endfunction

   function automatic logic [IW-1:0] fill(input logic [W-1:0] v);
      return {N{v}};
   endfunction

   // Offer one row and hold it until the handshake completes (bounded).
   task automatic send(input logic [IW-1:0] o, input logic [IW-1:0] c);
      bit acc;
      acc      = 1'b0;
      ORG      = o;
      CUR      = c;
      in_valid = 1'b1;
      for (int k = 0; k < 500 && !acc; k++) begin
         @(negedge clk);
         acc = (in_ready === 1'b1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("send_accepted", acc, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      idle(1);
      clr = 1'b0;
   endtask

   initial begin
      // Power-on reset.
      idle(3);
      rst = 1'b1;
      idle(1);
      check("in_ready_after_reset", in_ready, 1'b1);
      out_ready = 1'b1;

      // Extremes: +255 then -255 in every lane.
      send(fill(8'd255), fill(8'd0));
      send(fill(8'd0), fill(8'd255));
      idle(3);

      // Backpressure: A to output, B to skid, C stalls.
      out_ready = 1'b0;
      send(rand_row(), rand_row());
      send(rand_row(), rand_row());
      ORG      = rand_row();
      CUR      = rand_row();
      in_valid = 1'b1;
      idle(3);
      @(negedge clk);
      check("in_ready_low_when_skid_full", in_ready, 1'b0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(ORG, CUR);
      idle(5);

      // Nine rows from a fresh block: row indices 0..7,0.
      pulse_clr();
      for (int k = 0; k < 9; k++) send(rand_row(), rand_row());
      idle(4);

      // clr with a coincident input row and a held output.
      for (int k = 0; k < 3; k++) send(rand_row(), rand_row());
      out_ready = 1'b0;
      clr       = 1'b1;
      in_valid  = 1'b1;
      ORG       = rand_row();
      CUR       = rand_row();
      idle(1);
      clr      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("clr_empties_output", out_valid, 1'b0);
      check("clr_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(rand_row(), rand_row());
      idle(3);

      // Block SAD pattern: all diffs -1, then all diffs 0.
      pulse_clr();
      for (int k = 0; k < BR; k++) send(fill(8'd10), fill(8'd11));
      for (int k = 0; k < BR; k++) send(fill(8'd77), fill(8'd77));
      idle(4);

      // Randomized traffic with random gaps and backpressure.
      ready_mode = 2;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         send(rand_row(), rand_row());
      end
      ready_mode = 0;
      out_ready  = 1'b1;
      idle(4);

      // Mid-stream reset with rows held in both entries.
      out_ready = 1'b0;
      send(rand_row(), rand_row());
      send(rand_row(), rand_row());
      rst = 1'b0;
      idle(3);
      rst = 1'b1;
      idle(1);
      check("in_ready_after_midstream_reset", in_ready, 1'b1);
      out_ready = 1'b1;
      send(rand_row(), rand_row());

      // Bounded drain of the scoreboard.
      for (int k = 0; k < 100 && q.size() != 0; k++) idle(1);
      check("scoreboard_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
